// File: rtl/mc_controller_if.sv
// Control bus between the multicycle ARM controller and its datapath.
// master = controller (drives selects/enables), slave = datapath side.
interface mc_controller_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         MemWrite;
  logic         RegWrite;
  logic         IRWrite;
  logic         AdrSrc;
  logic [1:0]   RegSrc;
  logic [1:0]   ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ResultSrc;
  logic [1:0]   ImmSrc;
  logic [1:0]   ALUControl;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM, instruction decoder, NZCV flags
// register and condition check. Outputs are registered for the state being
// entered, then forced to zero combinationally while reset is low.
// Optional feature: define MC_CTRL_CMP_EN to support CMP (cmd 1010).
module mc_controller (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_control;
  } ctl_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  ctl_t       ctl_q, ctl_d;

  logic [1:0] op;
  logic [3:0] cmd;
  logic [3:0] cond;
  logic       i_bit;
  logic       s_bit;
  logic       l_bit;
  logic [1:0] alu_ctl;
  logic       dp_nop;
  logic       dp_arith;
  logic       is_cmp;
  logic       instr_unused;

  assign cond         = bus.Instr[31:28];
  assign op           = bus.Instr[27:26];
  assign i_bit        = bus.Instr[25];
  assign cmd          = bus.Instr[24:21];
  assign s_bit        = bus.Instr[20];
  assign l_bit        = bus.Instr[20];
  assign instr_unused = ^bus.Instr[19:12];

  // ARM condition field evaluated against the stored NZCV
  function automatic logic cond_check(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return c && !z;
      4'b1001: return !c || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Moore output table; ce gates the architectural side effects
  function automatic ctl_t ctl_for(input state_t st, input logic ce, input logic [1:0] ac);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR:   c.alu_src_b = 2'b01;
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = ce;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = ce;
      end
      S_EXECUTER: c.alu_control = ac;
      S_EXECUTEI: begin
        c.alu_src_b   = 2'b01;
        c.alu_control = ac;
      end
      S_ALUWB:    c.reg_write = ce;
      S_BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.pc_write   = ce;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // DP command decode; unsupported commands are NOPs that drive ADD
  always_comb begin
    alu_ctl  = 2'b00;
    dp_nop   = 1'b0;
    dp_arith = 1'b0;
    is_cmp   = 1'b0;
    case (cmd)
      4'b0100: begin alu_ctl = 2'b00; dp_arith = 1'b1; end
      4'b0010: begin alu_ctl = 2'b01; dp_arith = 1'b1; end
      4'b0000: alu_ctl = 2'b10;
      4'b1100: alu_ctl = 2'b11;
`ifdef MC_CTRL_CMP_EN
      4'b1010: begin alu_ctl = 2'b01; dp_arith = 1'b1; is_cmp = 1'b1; end
`else
`endif
      default: dp_nop = 1'b1;
    endcase
  end

  // Next state, condition latch, flag update and next registered outputs
  always_comb begin
    state_d   = S_FETCH;
    cond_ex_d = cond_ex_q;
    flags_d   = flags_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        cond_ex_d = cond_check(cond, flags_q);
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI: begin
        state_d = (dp_nop || is_cmp) ? S_FETCH : S_ALUWB;
        if (cond_ex_q && !dp_nop) begin
          if (is_cmp) begin
            flags_d = bus.ALUFlags;
          end else if (s_bit) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (dp_arith) flags_d[1:0] = bus.ALUFlags[1:0];
          end
        end
      end
      default:   state_d = S_FETCH;
    endcase
    ctl_d = ctl_for(state_d, cond_ex_d, alu_ctl);
  end

  // State, flags, condition and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
      ctl_q     <= ctl_for(S_FETCH, 1'b0, 2'b00);
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
      ctl_q     <= ctl_d;
    end
  end

  assign bus.PCWrite    = reset & ctl_q.pc_write;
  assign bus.MemWrite   = reset & ctl_q.mem_write;
  assign bus.RegWrite   = reset & ctl_q.reg_write;
  assign bus.IRWrite    = reset & ctl_q.ir_write;
  assign bus.AdrSrc     = reset & ctl_q.adr_src;
  assign bus.ALUSrcA    = reset ? ctl_q.alu_src_a   : 2'b00;
  assign bus.ALUSrcB    = reset ? ctl_q.alu_src_b   : 2'b00;
  assign bus.ResultSrc  = reset ? ctl_q.result_src  : 2'b00;
  assign bus.ALUControl = reset ? ctl_q.alu_control : 2'b00;
  assign bus.RegSrc     = reset ? {op == 2'b01, op == 2'b10} : 2'b00;
  assign bus.ImmSrc     = reset ? op : 2'b00;

endmodule
